// File: rtl/pulse_measure.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | pulse_measure: measures arm-to-rise delay and high time of pulse_in.   |
// | Revision: 1.0                                                          |
// +------------------------------------------------------------------------+
module pulse_measure #(
  parameter int count_width = 16
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   arm,
  input  logic                   pulse_in,
  input  logic                   result_ack,
  output logic                   busy,
  output logic                   result_valid,
  output logic [count_width-1:0] delay_count,
  output logic [count_width-1:0] width_count,
  output logic                   overflow
);

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_WAIT_LOW  = 3'd1,
    ST_WAIT_RISE = 3'd2,
    ST_MEASURE   = 3'd3,
    ST_DONE      = 3'd4
  } state_t;

  localparam logic [count_width-1:0] c_max  = '1;
  localparam logic [count_width-1:0] c_zero = '0;
  localparam logic [count_width-1:0] c_one  = {{(count_width-1){1'b0}}, 1'b1};

  state_t                 r_state, w_state_nxt;
  logic [count_width-1:0] r_delay, r_width, w_delay_nxt, w_width_nxt;
  logic [count_width-1:0] w_delay_inc, w_width_inc;
  logic                   r_ovf, w_ovf_nxt;
  logic                   r_busy, r_valid;
  logic                   w_launch;

  assign w_delay_inc = r_delay + c_one;
  assign w_width_inc = r_width + c_one;

  always_comb begin
    w_state_nxt = r_state;
    w_delay_nxt = r_delay;
    w_width_nxt = r_width;
    w_ovf_nxt   = r_ovf;
    w_launch    = 1'b0;
    case (r_state)
      ST_IDLE: w_launch = arm;
      ST_WAIT_LOW: begin
        w_delay_nxt = w_delay_inc;
        if (w_delay_inc == c_max) begin
          w_ovf_nxt   = 1'b1;
          w_width_nxt = c_zero;
          w_state_nxt = ST_DONE;
        end else if (!pulse_in) begin
          w_state_nxt = ST_WAIT_RISE;
        end
      end
      ST_WAIT_RISE: begin
        if (pulse_in) begin
          w_width_nxt = c_one;
          w_state_nxt = ST_MEASURE;
        end else begin
          w_delay_nxt = w_delay_inc;
          if (w_delay_inc == c_max) begin
            w_ovf_nxt   = 1'b1;
            w_width_nxt = c_zero;
            w_state_nxt = ST_DONE;
          end
        end
      end
      ST_MEASURE: begin
        if (!pulse_in) begin
          w_state_nxt = ST_DONE;
        end else if (r_width != c_max) begin
          w_width_nxt = w_width_inc;
          if (w_width_inc == c_max) w_ovf_nxt = 1'b1;
        end
      end
      ST_DONE: begin
        if (result_ack) begin
          if (arm) w_launch = 1'b1;
          else     w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
    // A high level at arm time must first go low, so it never counts as a rise.
    if (w_launch) begin
      w_delay_nxt = c_zero;
      w_width_nxt = c_zero;
      w_ovf_nxt   = 1'b0;
      w_state_nxt = pulse_in ? ST_WAIT_LOW : ST_WAIT_RISE;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_state <= ST_IDLE;
      r_delay <= c_zero;
      r_width <= c_zero;
      r_ovf   <= 1'b0;
      r_busy  <= 1'b0;
      r_valid <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_delay <= w_delay_nxt;
      r_width <= w_width_nxt;
      r_ovf   <= w_ovf_nxt;
      r_busy  <= (w_state_nxt == ST_WAIT_LOW) || (w_state_nxt == ST_WAIT_RISE) ||
                 (w_state_nxt == ST_MEASURE);
      r_valid <= (w_state_nxt == ST_DONE);
    end
  end

  assign busy         = r_busy;
  assign result_valid = r_valid;
  assign delay_count  = r_delay;
  assign width_count  = r_width;
  assign overflow     = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_pulse_measure.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | tb_pulse_measure: directed vector bench for pulse_measure.             |
// | Revision: 1.0                                                          |
// +------------------------------------------------------------------------+
module tb_pulse_measure;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        a_reset = 1'b0, a_arm = 1'b0, a_pin = 1'b0, a_ack = 1'b0;
  logic        a_busy, a_valid, a_ovf;
  logic [15:0] a_delay, a_width;

  logic        b_reset = 1'b0, b_arm = 1'b0, b_pin = 1'b0, b_ack = 1'b0;
  logic        b_busy, b_valid, b_ovf;
  logic [3:0]  b_delay, b_width;

  pulse_measure #(.count_width(16)) dut_a (
    .clock(clk), .reset(a_reset), .arm(a_arm), .pulse_in(a_pin), .result_ack(a_ack),
    .busy(a_busy), .result_valid(a_valid), .delay_count(a_delay),
    .width_count(a_width), .overflow(a_ovf)
  );

  pulse_measure #(.count_width(4)) dut_b (
    .clock(clk), .reset(b_reset), .arm(b_arm), .pulse_in(b_pin), .result_ack(b_ack),
    .busy(b_busy), .result_valid(b_valid), .delay_count(b_delay),
    .width_count(b_width), .overflow(b_ovf)
  );

  typedef struct {
    bit          sel_b;
    logic        rst, arm, pin, ack;
    logic        busy, valid, ovf;
    logic [15:0] dly, wid;
    string       name;
  } vec_t;

  vec_t vecs[$];
  int   n_checks = 0;
  int   n_errors = 0;

  function automatic void add(input bit sel_b, input logic rst, arm, pin, ack,
                              input logic busy, valid, input int dly, wid,
                              input logic ovf, input string name);
    vec_t v;
    v.sel_b = sel_b; v.rst = rst; v.arm = arm; v.pin = pin; v.ack = ack;
    v.busy = busy; v.valid = valid; v.dly = 16'(dly); v.wid = 16'(wid);
    v.ovf = ovf; v.name = name;
    vecs.push_back(v);
  endfunction

  task automatic apply(input vec_t v);
    logic        g_busy, g_valid, g_ovf;
    logic [15:0] g_dly, g_wid;
    @(negedge clk);
    if (v.sel_b) begin
      b_reset = v.rst; b_arm = v.arm; b_pin = v.pin; b_ack = v.ack;
    end else begin
      a_reset = v.rst; a_arm = v.arm; a_pin = v.pin; a_ack = v.ack;
    end
    @(posedge clk);
    #1;
    if (v.sel_b) begin
      g_busy = b_busy; g_valid = b_valid; g_ovf = b_ovf;
      g_dly = {12'd0, b_delay}; g_wid = {12'd0, b_width};
    end else begin
      g_busy = a_busy; g_valid = a_valid; g_ovf = a_ovf;
      g_dly = a_delay; g_wid = a_width;
    end
    n_checks++;
    if ({g_busy, g_valid, g_ovf, g_dly, g_wid} !== {v.busy, v.valid, v.ovf, v.dly, v.wid}) begin
      n_errors++;
      $display("FAIL %s: got busy=%b valid=%b delay=%0d width=%0d ovf=%b, expected busy=%b valid=%b delay=%0d width=%0d ovf=%b",
               v.name, g_busy, g_valid, g_dly, g_wid, g_ovf,
               v.busy, v.valid, v.dly, v.wid, v.ovf);
    end
  endtask

  task automatic step_b(input logic rst, arm, pin, ack, input logic busy, valid,
                        input int dly, wid, input logic ovf, input string name);
    vec_t v;
    v.sel_b = 1'b1; v.rst = rst; v.arm = arm; v.pin = pin; v.ack = ack;
    v.busy = busy; v.valid = valid; v.dly = 16'(dly); v.wid = 16'(wid);
    v.ovf = ovf; v.name = name;
    apply(v);
  endtask

  initial begin
    // ---- table for the 16-bit instance ----
    add(0, 0,0,0,0, 0,0, 0,0, 0, "reset");
    add(0, 1,0,0,0, 0,0, 0,0, 0, "idle");
    add(0, 1,0,1,1, 0,0, 0,0, 0, "ack_in_idle");
    // delay 10, width 4
    add(0, 1,1,0,0, 1,0, 0,0, 0, "arm_low");
    for (int k = 1; k <= 10; k++)
      add(0, 1,(k == 5),0,0, 1,0, k,0, 0, "wait_rise");
    add(0, 1,0,1,0, 1,0, 10,1, 0, "rise");
    for (int k = 2; k <= 4; k++)
      add(0, 1,(k == 2),1,(k == 3), 1,0, 10,k, 0, "measure");
    add(0, 1,0,0,0, 0,1, 10,4, 0, "done_10_4");
    add(0, 1,1,1,0, 0,1, 10,4, 0, "done_arm_no_ack");
    add(0, 1,0,0,1, 0,0, 10,4, 0, "ack_to_idle");
    // high at arm: delay 6, width 2
    add(0, 1,1,1,0, 1,0, 0,0, 0, "arm_high");
    for (int k = 1; k <= 3; k++) add(0, 1,0,1,0, 1,0, k,0, 0, "wait_low_hi");
    for (int k = 4; k <= 6; k++) add(0, 1,0,0,0, 1,0, k,0, 0, "wait_low_lo");
    add(0, 1,0,1,0, 1,0, 6,1, 0, "rise2");
    add(0, 1,0,1,0, 1,0, 6,2, 0, "measure2");
    add(0, 1,0,0,0, 0,1, 6,2, 0, "done_6_2");
    // direct re-arm from DONE, then reset mid-measure
    add(0, 1,1,0,1, 1,0, 0,0, 0, "rearm");
    add(0, 1,0,1,0, 1,0, 0,1, 0, "rearm_rise");
    add(0, 1,0,1,0, 1,0, 0,2, 0, "rearm_measure");
    add(0, 0,0,1,0, 0,0, 0,0, 0, "reset_mid");
    add(0, 1,0,1,0, 0,0, 0,0, 0, "post_reset_hi");
    add(0, 1,0,0,0, 0,0, 0,0, 0, "post_reset_lo");
    add(0, 1,0,1,0, 0,0, 0,0, 0, "post_reset_rise");
    add(0, 1,0,0,0, 0,0, 0,0, 0, "post_reset_fall");
    add(0, 1,0,0,0, 0,0, 0,0, 0, "still_idle");

    foreach (vecs[i]) apply(vecs[i]);

    // ---- 4-bit instance: delay timeout ----
    step_b(0,0,0,0, 0,0, 0,0, 0, "b_reset");
    step_b(1,1,0,0, 1,0, 0,0, 0, "b_arm");
    for (int k = 1; k <= 14; k++) step_b(1,0,0,0, 1,0, k,0, 0, "b_wait");
    step_b(1,0,0,0, 0,1, 15,0, 1, "b_timeout");
    step_b(1,0,1,0, 0,1, 15,0, 1, "b_timeout_hold");

    // ---- 4-bit instance: width saturation ----
    step_b(1,1,0,1, 1,0, 0,0, 0, "b_rearm");
    step_b(1,0,1,0, 1,0, 0,1, 0, "b_rise");
    for (int k = 2; k <= 20; k++)
      step_b(1,0,1,0, 1,0, 0,(k > 15) ? 15 : k, (k >= 15), "b_width");
    step_b(1,0,0,0, 0,1, 0,15, 1, "b_width_done");
    step_b(1,0,0,1, 0,0, 0,15, 1, "b_ack");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
